// File: rtl/polyvec_matvec_sched.sv
// polyvec_matvec_sched
//   Sequencer for the NTT-domain matrix-vector product t = A*v. Walks
//   (i, j, n) with n fastest, then j, then i, presenting one coefficient-pair
//   address per enabled cycle to the pointwise multiplier. A tag pipe of
//   MUL_LAT stages tracks each issued tuple so the accumulator write arrives
//   with the multiplier result: overwrite on j==0, add on j>0.
// Ports
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start             begin a product (honoured in IDLE only)
//   stall             freeze issue and tag pipe for this cycle
//   busy, done        run in progress / one-cycle completion pulse
//   mul_en            multiplier pipe clock enable (= ~stall)
//   issue_valid       mat_addr / vec_addr carry a tuple this cycle
//   mat_addr          (i*L+j)*N+n
//   vec_addr          j*N+n
//   acc_we            multiplier result present, write accumulator
//   acc_first         overwrite instead of add (tuple had j==0)
//   acc_addr          i*N+n of the result leaving the pipe
//   row_done          result is the final contribution (j==L-1)
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one tuple per unstalled cycle
// DRAIN | all tuples issued, waiting for tag pipe to empty
// DONE  | done pulse, back to IDLE
module polyvec_matvec_sched #(
  parameter int K       = 6,
  parameter int L       = 5,
  parameter int N       = 256,
  parameter int MUL_LAT = 3,
  parameter int MAT_W   = $clog2(K*L*N),
  parameter int VEC_W   = $clog2(L*N),
  parameter int ACC_W   = $clog2(K*N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic             mul_en,
  output logic             issue_valid,
  output logic [MAT_W-1:0] mat_addr,
  output logic [VEC_W-1:0] vec_addr,
  output logic             acc_we,
  output logic             acc_first,
  output logic [ACC_W-1:0] acc_addr,
  output logic             row_done
);

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;

  logic [NW-1:0]    n_cnt;
  logic [LW-1:0]    j_cnt;
  logic [KW-1:0]    i_cnt;
  logic [ACC_W-1:0] row_base;  // i*N, kept by increment

  logic [MUL_LAT-1:0] tag_valid;
  logic [MUL_LAT-1:0] tag_first;
  logic [MUL_LAT-1:0] tag_last;
  logic [ACC_W-1:0]   tag_addr [MUL_LAT];

  logic last_n, last_j, last_i, last_all, upstream_empty;

  assign last_n   = (n_cnt == NW'(N-1));
  assign last_j   = (j_cnt == LW'(L-1));
  assign last_i   = (i_cnt == KW'(K-1));
  assign last_all = last_n && last_j && last_i;

  assign mul_en      = !stall;
  assign issue_valid = (state == ISSUE) && !stall;

  assign acc_we    = tag_valid[MUL_LAT-1] && !stall;
  assign acc_first = tag_first[MUL_LAT-1];
  assign row_done  = tag_last[MUL_LAT-1];
  assign acc_addr  = tag_addr[MUL_LAT-1];

  // Everything ahead of the final stage is empty: the result now at the
  // output is the last one, so the next enabled cycle retires the run.
  always_comb begin
    upstream_empty = 1'b1;
    for (int s = 0; s < MUL_LAT-1; s++) begin
      if (tag_valid[s]) upstream_empty = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      n_cnt     <= '0;
      j_cnt     <= '0;
      i_cnt     <= '0;
      row_base  <= '0;
      mat_addr  <= '0;
      vec_addr  <= '0;
      tag_valid <= '0;
      tag_first <= '0;
      tag_last  <= '0;
      for (int s = 0; s < MUL_LAT; s++) tag_addr[s] <= '0;
    end else begin
      done <= 1'b0;

      if (!stall) begin
        for (int s = MUL_LAT-1; s > 0; s--) begin
          tag_valid[s] <= tag_valid[s-1];
          tag_first[s] <= tag_first[s-1];
          tag_last[s]  <= tag_last[s-1];
          tag_addr[s]  <= tag_addr[s-1];
        end
        tag_valid[0] <= issue_valid;
        tag_first[0] <= (j_cnt == '0);
        tag_last[0]  <= last_j;
        tag_addr[0]  <= row_base + ACC_W'(n_cnt);
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            n_cnt    <= '0;
            j_cnt    <= '0;
            i_cnt    <= '0;
            row_base <= '0;
            mat_addr <= '0;
            vec_addr <= '0;
          end
        end
        ISSUE: begin
          if (!stall) begin
            if (last_all) begin
              state    <= DRAIN;
              n_cnt    <= '0;
              j_cnt    <= '0;
              i_cnt    <= '0;
              row_base <= '0;
              mat_addr <= '0;
              vec_addr <= '0;
            end else begin
              mat_addr <= mat_addr + MAT_W'(1);
              vec_addr <= (last_n && last_j) ? '0 : vec_addr + VEC_W'(1);
              if (!last_n) begin
                n_cnt <= n_cnt + NW'(1);
              end else begin
                n_cnt <= '0;
                if (!last_j) begin
                  j_cnt <= j_cnt + LW'(1);
                end else begin
                  j_cnt    <= '0;
                  i_cnt    <= i_cnt + KW'(1);
                  row_base <= row_base + ACC_W'(N);
                end
              end
            end
          end
        end
        DRAIN: begin
          if (!stall && upstream_empty) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_polyvec_matvec_sched.sv
module tb_polyvec_matvec_sched;

  localparam int K = 6, L = 5, N = 256, MUL_LAT = 3;
  localparam int TOTAL = K*L*N;

  logic        clock = 1'b0;
  logic        reset, start, stall;
  logic        busy, done, mul_en, issue_valid;
  logic [12:0] mat_addr;
  logic [10:0] vec_addr;
  logic        acc_we, acc_first, row_done;
  logic [10:0] acc_addr;

  polyvec_matvec_sched #(.K(K), .L(L), .N(N), .MUL_LAT(MUL_LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .busy(busy), .done(done), .mul_en(mul_en), .issue_valid(issue_valid),
    .mat_addr(mat_addr), .vec_addr(vec_addr), .acc_we(acc_we),
    .acc_first(acc_first), .acc_addr(acc_addr), .row_done(row_done)
  );

  always #5 clock = ~clock;

  typedef struct { int mat; int vec; int ord; } iss_t;
  typedef struct { int addr; int first; int last; int ord; } acc_t;

  iss_t iss_q[$];
  acc_t acc_q[$];
  int   done_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int en_total = 0;
  int start_cyc = 0;
  int iss_idx, acc_idx, cnt_first, cnt_last;
  int wr_cnt [K*N];
  int cap_mat0, cap_vec0, cap_mat256, cap_vec256, cap_mat1280, cap_vec1280;
  int cap_mat7679, cap_vec7679, cap_first256, cap_addr1280, cap_first1280;
  int cap_last7679, cap_addr7679;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  always @(negedge clock) begin
    if (!stall) en_total++;
    check("mul_en", int'(mul_en), int'(!stall));
    if (stall) check("acc_we_while_stalled", int'(acc_we), 0);

    if (issue_valid) begin
      if (iss_q.size() == 0) check("unexpected_issue", 1, 0);
      else begin
        iss_t e;
        e = iss_q.pop_front();
        vectors++;
        if (mat_addr != e.mat || vec_addr != e.vec || en_total != e.ord) begin
          miscompares++;
          $display("FAIL issue#%0d: got mat=%0d vec=%0d ord=%0d expected mat=%0d vec=%0d ord=%0d",
                   iss_idx, mat_addr, vec_addr, en_total, e.mat, e.vec, e.ord);
        end
      end
      if (iss_idx == 0)    begin cap_mat0 = mat_addr;    cap_vec0 = vec_addr;    end
      if (iss_idx == 256)  begin cap_mat256 = mat_addr;  cap_vec256 = vec_addr;  end
      if (iss_idx == 1280) begin cap_mat1280 = mat_addr; cap_vec1280 = vec_addr; end
      if (iss_idx == 7679) begin cap_mat7679 = mat_addr; cap_vec7679 = vec_addr; end
      iss_idx++;
    end else if (stall && busy && iss_q.size() > 0) begin
      check("addr_hold_in_stall", int'(mat_addr), iss_q[0].mat);
    end

    if (acc_we) begin
      if (acc_q.size() == 0) check("unexpected_acc_we", 1, 0);
      else begin
        acc_t a;
        a = acc_q.pop_front();
        vectors++;
        if (acc_addr != a.addr || acc_first != a.first[0] || row_done != a.last[0] || en_total != a.ord) begin
          miscompares++;
          $display("FAIL acc#%0d: got addr=%0d first=%0d last=%0d ord=%0d expected addr=%0d first=%0d last=%0d ord=%0d",
                   acc_idx, acc_addr, acc_first, row_done, en_total, a.addr, a.first, a.last, a.ord);
        end
      end
      cnt_first += int'(acc_first);
      cnt_last  += int'(row_done);
      if (int'(acc_addr) < K*N) wr_cnt[acc_addr]++;
      if (acc_idx == 256)  cap_first256 = acc_first;
      if (acc_idx == 1280) begin cap_addr1280 = acc_addr; cap_first1280 = acc_first; end
      if (acc_idx == 7679) begin cap_last7679 = row_done; cap_addr7679 = acc_addr; end
      acc_idx++;
    end

    if (done) begin
      if (done_q.size() == 0) check("unexpected_done", 1, 0);
      else check("done_cycle", cyc, done_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_rel(input int r);
    while (cyc < start_cyc + r) tick();
  endtask

  // Raises start in the current cycle and loads the expected stream.
  task automatic start_run(input int done_delta);
    int base, k;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clock);
    #1;
    base = en_total;
    iss_idx = 0; acc_idx = 0; cnt_first = 0; cnt_last = 0;
    for (int a = 0; a < K*N; a++) wr_cnt[a] = 0;
    cap_mat0 = -1; cap_vec0 = -1; cap_mat256 = -1; cap_vec256 = -1;
    cap_mat1280 = -1; cap_vec1280 = -1; cap_mat7679 = -1; cap_vec7679 = -1;
    cap_first256 = -1; cap_addr1280 = -1; cap_first1280 = -1;
    cap_last7679 = -1; cap_addr7679 = -1;
    k = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < L; j++)
        for (int n = 0; n < N; n++) begin
          iss_q.push_back('{mat: (i*L+j)*N+n, vec: j*N+n, ord: base+k+1});
          acc_q.push_back('{addr: i*N+n, first: (j == 0) ? 1 : 0,
                            last: (j == L-1) ? 1 : 0, ord: base+k+1+MUL_LAT});
          k++;
        end
    if (done_delta > 0) done_q.push_back(start_cyc + done_delta);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic check_run_end(input string tag);
    int bad;
    check({tag, "_iss_q_left"}, iss_q.size(), 0);
    check({tag, "_acc_q_left"}, acc_q.size(), 0);
    check({tag, "_done_q_left"}, done_q.size(), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_first_mat"}, cap_mat0, 0);
    check({tag, "_first_vec"}, cap_vec0, 0);
    check({tag, "_iss257_mat"}, cap_mat256, 256);
    check({tag, "_iss257_vec"}, cap_vec256, 256);
    check({tag, "_acc257_first"}, cap_first256, 0);
    check({tag, "_iss1281_mat"}, cap_mat1280, 1280);
    check({tag, "_iss1281_vec"}, cap_vec1280, 0);
    check({tag, "_acc1281_addr"}, cap_addr1280, 256);
    check({tag, "_acc1281_first"}, cap_first1280, 1);
    check({tag, "_iss7680_mat"}, cap_mat7679, 7679);
    check({tag, "_iss7680_vec"}, cap_vec7679, 1279);
    check({tag, "_acc7680_row_done"}, cap_last7679, 1);
    check({tag, "_acc7680_addr"}, cap_addr7679, 1535);
    check({tag, "_issue_count"}, iss_idx, 7680);
    check({tag, "_acc_first_count"}, cnt_first, 1536);
    check({tag, "_row_done_count"}, cnt_last, 1536);
    bad = 0;
    for (int a = 0; a < K*N; a++) if (wr_cnt[a] != L) bad++;
    check({tag, "_addrs_not_written_5x"}, bad, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0;
    repeat (3) tick();
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_issue_valid", int'(issue_valid), 0);
    check("reset_acc_we", int'(acc_we), 0);
    check("reset_mat_addr", int'(mat_addr), 0);
    reset = 1'b0;
    repeat (2) tick();

    // Run A: no stall, done at start+7684
    start_run(TOTAL + MUL_LAT + 1);
    wait_rel(3);
    check("A_busy_c3", int'(busy), 1);
    wait_rel(7690);
    check_run_end("A");

    // Run B: 10 stalls in ISSUE, 5 in DRAIN, stray starts mid-run and in DONE
    tick();
    start_run(TOTAL + MUL_LAT + 1 + 15);
    wait_rel(100); stall = 1'b1;
    wait_rel(110); stall = 1'b0;
    wait_rel(500); start = 1'b1;
    tick();        start = 1'b0;
    wait_rel(7691); stall = 1'b1;
    wait_rel(7696); stall = 1'b0;
    wait_rel(7698);
    check("B_busy_last_drain", int'(busy), 1);
    wait_rel(7699); start = 1'b1; stall = 1'b1;
    tick();         start = 1'b0; stall = 1'b0;
    wait_rel(7720);
    check_run_end("B");

    // Run C: second clean run after done
    tick();
    start_run(TOTAL + MUL_LAT + 1);
    wait_rel(7690);
    check_run_end("C");

    // Run D: reset mid-run aborts without done
    tick();
    start_run(0);
    wait_rel(3000); reset = 1'b1;
    @(negedge clock);
    #1;
    iss_q.delete();
    acc_q.delete();
    tick();
    reset = 1'b0;
    check("D_busy_after_reset", int'(busy), 0);
    check("D_issue_after_reset", int'(issue_valid), 0);
    check("D_acc_we_after_reset", int'(acc_we), 0);
    check("D_done_after_reset", int'(done), 0);
    wait_rel(3100);
    check("D_busy_idle", int'(busy), 0);

    // Run E: clean run after abort
    tick();
    start_run(TOTAL + MUL_LAT + 1);
    wait_rel(7690);
    check_run_end("E");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
